// File: rtl/vlsu_pkg.sv
// Shared types and helpers for the vector load sequencer: FSM state encoding,
// staging register size and the per-word byte-enable computation.
package vlsu_pkg;

  localparam int VLEN_BYTES = 16;
  localparam int CNT_W      = $clog2(VLEN_BYTES) + 1;

  typedef enum logic [2:0] {
    LD_IDLE  = 3'd0,
    LD_CLEAR = 3'd1,
    LD_REQ   = 3'd2,
    LD_WAIT  = 3'd3,
    LD_DRAIN = 3'd4,
    LD_DONE  = 3'd5
  } ld_state_e;

  typedef struct packed {
    logic [3:0] be;
    logic [2:0] n;
  } be_res_t;

  // Bytes taken from one word: limited by what remains and by the room left above the offset.
  function automatic be_res_t be_mask(input logic [1:0] off, input logic [CNT_W-1:0] rem);
    be_res_t    res;
    logic [2:0] room;
    logic [2:0] n;
    logic [3:0] mask;
    room = 3'd4 - {1'b0, off};
    if (rem < CNT_W'(room)) begin
      n = rem[2:0];
    end else begin
      n = room;
    end
    case (n)
      3'd0:    mask = 4'b0000;
      3'd1:    mask = 4'b0001;
      3'd2:    mask = 4'b0011;
      3'd3:    mask = 4'b0111;
      default: mask = 4'b1111;
    endcase
    res.be = mask << off;
    res.n  = n;
    return res;
  endfunction

endpackage

// File: rtl/vlsu_ld_be_gen.sv
// Combinational byte-enable generator: word offset and remaining byte count
// to the byte-enable mask and the number of bytes covered by this word.
module vlsu_ld_be_gen
  import vlsu_pkg::*;
(
  input  logic [1:0]       off_i,
  input  logic [CNT_W-1:0] rem_i,
  output logic [3:0]       be_o,
  output logic [2:0]       n_o
);

  be_res_t res_s;

  assign res_s = be_mask(off_i, rem_i);
  assign be_o  = res_s.be;
  assign n_o   = res_s.n;

endmodule

// File: rtl/vlsu_load_sequencer.sv
// Splits a unit-stride vector load into word-aligned reads (one outstanding)
// and steers the returned bytes into the 128-bit staging register.
module vlsu_load_sequencer
  import vlsu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic [CNT_W-1:0]  num_bytes_i,
  input  logic              kill_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              data_req_o,
  output logic [ADDR_W-1:0] data_addr_o,
  output logic [3:0]        data_be_o,
  input  logic              data_gnt_i,
  input  logic              data_rvalid_i,
  output logic              clear_register_o,
  output logic              byte_enable_valid_o,
  output logic [3:0]        byte_enable_o,
  output logic              read_data_valid_o,
  output logic [6:0]        byte_select_o
);

  ld_state_e         state_q, state_d;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic [CNT_W-1:0]  rem_q, rem_d;
  logic [CNT_W-1:0]  sel_q, sel_d;
  logic [2:0]        n_q;

  logic              busy_q;
  logic              done_q;
  logic              req_q;
  logic              clear_q;
  logic [ADDR_W-1:0] addr_q;
  logic [3:0]        be_q;
  logic [CNT_W-1:0]  sel_out_q;

  logic [3:0]        gen_be_s;
  logic [2:0]        gen_n_s;

  // Mask for the word about to be requested, so request outputs can be registered.
  vlsu_ld_be_gen u_be_gen (
    .off_i (cur_addr_d[1:0]),
    .rem_i (rem_d),
    .be_o  (gen_be_s),
    .n_o   (gen_n_s)
  );

  // Next-state and datapath update logic.
  always_comb begin
    state_d    = state_q;
    cur_addr_d = cur_addr_q;
    rem_d      = rem_q;
    sel_d      = sel_q;
    case (state_q)
      LD_IDLE: begin
        if (start_i) begin
          cur_addr_d = base_addr_i;
          rem_d      = (num_bytes_i > CNT_W'(VLEN_BYTES)) ? CNT_W'(VLEN_BYTES) : num_bytes_i;
          sel_d      = '0;
          state_d    = LD_CLEAR;
        end else begin
          state_d = LD_IDLE;
        end
      end
      LD_CLEAR: begin
        if (kill_i) begin
          state_d = LD_IDLE;
        end else if (rem_q == '0) begin
          state_d = LD_DONE;
        end else begin
          state_d = LD_REQ;
        end
      end
      LD_REQ: begin
        // A granted read must still return before we can leave, even when killed.
        if (data_gnt_i) begin
          state_d = kill_i ? LD_DRAIN : LD_WAIT;
        end else if (kill_i) begin
          state_d = LD_IDLE;
        end else begin
          state_d = LD_REQ;
        end
      end
      LD_WAIT: begin
        if (kill_i) begin
          state_d = data_rvalid_i ? LD_IDLE : LD_DRAIN;
        end else if (data_rvalid_i) begin
          sel_d      = sel_q + CNT_W'(n_q);
          cur_addr_d = cur_addr_q + ADDR_W'(n_q);
          rem_d      = rem_q - CNT_W'(n_q);
          state_d    = (rem_q == CNT_W'(n_q)) ? LD_DONE : LD_REQ;
        end else begin
          state_d = LD_WAIT;
        end
      end
      LD_DRAIN: begin
        if (data_rvalid_i) begin
          state_d = LD_IDLE;
        end else begin
          state_d = LD_DRAIN;
        end
      end
      LD_DONE: begin
        state_d = LD_IDLE;
      end
      default: begin
        state_d = LD_IDLE;
      end
    endcase
  end

  // State, datapath and registered output flops.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= LD_IDLE;
      cur_addr_q <= '0;
      rem_q      <= '0;
      sel_q      <= '0;
      n_q        <= 3'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      req_q      <= 1'b0;
      clear_q    <= 1'b0;
      addr_q     <= '0;
      be_q       <= 4'd0;
      sel_out_q  <= '0;
    end else begin
      state_q    <= state_d;
      cur_addr_q <= cur_addr_d;
      rem_q      <= rem_d;
      sel_q      <= sel_d;
      busy_q     <= (state_d != LD_IDLE);
      done_q     <= (state_d == LD_DONE);
      req_q      <= (state_d == LD_REQ);
      clear_q    <= (state_d == LD_CLEAR);
      sel_out_q  <= (state_d == LD_WAIT) ? sel_d : '0;
      if (state_d == LD_REQ) begin
        addr_q <= {cur_addr_d[ADDR_W-1:2], 2'b00};
        be_q   <= gen_be_s;
        n_q    <= gen_n_s;
      end else begin
        addr_q <= '0;
        be_q   <= 4'd0;
        n_q    <= n_q;
      end
    end
  end

  assign busy_o              = busy_q;
  assign done_o              = done_q;
  assign data_req_o          = req_q;
  assign data_addr_o         = addr_q;
  assign data_be_o           = be_q;
  assign clear_register_o    = clear_q;
  assign byte_enable_o       = be_q;
  assign byte_select_o       = {{(7-CNT_W){1'b0}}, sel_out_q};
  assign byte_enable_valid_o = (state_q == LD_REQ) & data_gnt_i;
  assign read_data_valid_o   = (state_q == LD_WAIT) & data_rvalid_i & ~kill_i;

endmodule

// File: tb/tb_vlsu_load_sequencer.sv
// Directed self-checking bench for vlsu_load_sequencer with a simple
// single-outstanding memory responder and hand-computed beat tables.
module tb_vlsu_load_sequencer;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic [31:0] base_addr_i;
  logic [4:0]  num_bytes_i;
  logic        kill_i;
  logic        busy_o;
  logic        done_o;
  logic        data_req_o;
  logic [31:0] data_addr_o;
  logic [3:0]  data_be_o;
  logic        data_gnt_i;
  logic        data_rvalid_i;
  logic        clear_register_o;
  logic        byte_enable_valid_o;
  logic [3:0]  byte_enable_o;
  logic        read_data_valid_o;
  logic [6:0]  byte_select_o;

  int n_checks = 0;
  int n_errors = 0;
  int done_cnt = 0;

  logic [31:0] exp_addr [0:3];
  logic [3:0]  exp_be   [0:3];
  logic [6:0]  exp_sel  [0:3];
  logic [31:0] rec_addr [0:7];
  logic [3:0]  rec_be   [0:7];
  logic [6:0]  rec_sel  [0:7];
  logic        rec_bev  [0:7];
  logic        rec_rdv  [0:7];

  vlsu_load_sequencer dut (
    .clk_i               (clk_i),
    .rst_i               (rst_i),
    .start_i             (start_i),
    .base_addr_i         (base_addr_i),
    .num_bytes_i         (num_bytes_i),
    .kill_i              (kill_i),
    .busy_o              (busy_o),
    .done_o              (done_o),
    .data_req_o          (data_req_o),
    .data_addr_o         (data_addr_o),
    .data_be_o           (data_be_o),
    .data_gnt_i          (data_gnt_i),
    .data_rvalid_i       (data_rvalid_i),
    .clear_register_o    (clear_register_o),
    .byte_enable_valid_o (byte_enable_valid_o),
    .byte_enable_o       (byte_enable_o),
    .read_data_valid_o   (read_data_valid_o),
    .byte_select_o       (byte_select_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) begin
    if (done_o) done_cnt <= done_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  // Issues a start and checks the clear pulse in the following cycle.
  task automatic start_load(input logic [31:0] base, input logic [4:0] num);
    start_i     = 1'b1;
    base_addr_i = base;
    num_bytes_i = num;
    next_cycle();
    start_i = 1'b0;
    check_eq("clear_pulse", {31'd0, clear_register_o}, 32'd1);
    check_eq("busy_after_start", {31'd0, busy_o}, 32'd1);
  endtask

  task automatic wait_req(input string tag);
    int guard = 0;
    while (!data_req_o && guard < 10) begin
      next_cycle();
      guard++;
    end
    check_eq(tag, {31'd0, data_req_o}, 32'd1);
  endtask

  // Runs one load with a responder that grants after gnt_stall cycles and returns data the cycle after.
  task automatic run_load(input string tag, input logic [31:0] base, input logic [4:0] num,
                          input int gnt_stall, input int nexp);
    int          beats   = 0;
    int          stall   = 0;
    int          cyc     = 0;
    bit          pending = 1'b0;
    bit          got_done = 1'b0;
    bit          any_req = 1'b0;
    logic [31:0] hold_addr = 32'd0;
    logic [3:0]  hold_be   = 4'd0;
    start_load(base, num);
    while (cyc < 60 && !got_done) begin
      next_cycle();
      data_gnt_i    = 1'b0;
      data_rvalid_i = 1'b0;
      if (data_req_o) any_req = 1'b1;
      if (done_o) begin
        got_done = 1'b1;
      end else if (pending) begin
        data_rvalid_i = 1'b1;
        #1;
        rec_sel[beats] = byte_select_o;
        rec_rdv[beats] = read_data_valid_o;
        beats++;
        pending = 1'b0;
      end else if (data_req_o && beats < 8) begin
        if (stall == 0) begin
          hold_addr = data_addr_o;
          hold_be   = data_be_o;
        end else begin
          check_eq({tag, "_stall_addr"}, data_addr_o, hold_addr);
          check_eq({tag, "_stall_be"}, {28'd0, data_be_o}, {28'd0, hold_be});
        end
        if (stall < gnt_stall) begin
          check_eq({tag, "_bev_no_gnt"}, {31'd0, byte_enable_valid_o}, 32'd0);
          stall++;
        end else begin
          data_gnt_i = 1'b1;
          #1;
          rec_addr[beats] = data_addr_o;
          rec_be[beats]   = byte_enable_o;
          rec_bev[beats]  = byte_enable_valid_o;
          pending = 1'b1;
          stall   = 0;
        end
      end
      cyc++;
    end
    data_gnt_i    = 1'b0;
    data_rvalid_i = 1'b0;
    check_eq({tag, "_done"}, {31'd0, got_done}, 32'd1);
    check_eq({tag, "_beats"}, beats, nexp);
    if (nexp == 0) check_eq({tag, "_no_req"}, {31'd0, any_req}, 32'd0);
    for (int i = 0; i < nexp && i < beats; i++) begin
      check_eq({tag, "_addr"}, rec_addr[i], exp_addr[i]);
      check_eq({tag, "_be"}, {28'd0, rec_be[i]}, {28'd0, exp_be[i]});
      check_eq({tag, "_sel"}, {25'd0, rec_sel[i]}, {25'd0, exp_sel[i]});
      check_eq({tag, "_bev"}, {31'd0, rec_bev[i]}, 32'd1);
      check_eq({tag, "_rdv"}, {31'd0, rec_rdv[i]}, 32'd1);
    end
    next_cycle();
    check_eq({tag, "_done_one_cycle"}, {31'd0, done_o}, 32'd0);
    check_eq({tag, "_idle"}, {31'd0, busy_o}, 32'd0);
  endtask

  initial begin
    int d0;
    rst_i = 1'b1; start_i = 1'b0; base_addr_i = 32'd0; num_bytes_i = 5'd0;
    kill_i = 1'b0; data_gnt_i = 1'b0; data_rvalid_i = 1'b0;
    repeat (3) next_cycle();
    rst_i = 1'b0;
    next_cycle();
    check_eq("rst_busy", {31'd0, busy_o}, 32'd0);
    check_eq("rst_req", {31'd0, data_req_o}, 32'd0);
    check_eq("rst_addr", data_addr_o, 32'd0);
    check_eq("rst_sel", {25'd0, byte_select_o}, 32'd0);
    check_eq("rst_done_clear", {30'd0, done_o, clear_register_o}, 32'd0);

    exp_addr = '{32'h1000, 32'h1004, 32'h1008, 32'h100C};
    exp_be   = '{4'hF, 4'hF, 4'hF, 4'hF};
    exp_sel  = '{7'd0, 7'd4, 7'd8, 7'd12};
    d0 = done_cnt;
    run_load("aligned", 32'h1000, 5'd16, 0, 4);
    check_eq("aligned_done_count", done_cnt - d0, 32'd1);

    exp_addr = '{32'h1000, 32'h1004, 32'h1008, 32'h0};
    exp_be   = '{4'b1000, 4'b1111, 4'b0001, 4'h0};
    exp_sel  = '{7'd0, 7'd1, 7'd5, 7'd0};
    run_load("misaligned", 32'h1003, 5'd6, 0, 3);

    run_load("zero", 32'h1000, 5'd0, 0, 0);

    exp_addr = '{32'h2000, 32'h2004, 32'h2008, 32'h200C};
    exp_be   = '{4'hF, 4'hF, 4'hF, 4'hF};
    exp_sel  = '{7'd0, 7'd4, 7'd8, 7'd12};
    run_load("clip20", 32'h2000, 5'd20, 0, 4);

    exp_addr = '{32'h3000, 32'h3004, 32'h0, 32'h0};
    exp_be   = '{4'b1100, 4'b0011, 4'h0, 4'h0};
    exp_sel  = '{7'd0, 7'd2, 7'd0, 7'd0};
    run_load("stall", 32'h3002, 5'd4, 3, 2);

    // Kill while waiting for read data: drain the outstanding beat silently.
    d0 = done_cnt;
    start_load(32'h4000, 5'd8);
    wait_req("kill_wait_req");
    data_gnt_i = 1'b1;
    next_cycle();
    data_gnt_i = 1'b0;
    kill_i = 1'b1;
    next_cycle();
    kill_i = 1'b0;
    check_eq("drain_busy", {31'd0, busy_o}, 32'd1);
    check_eq("drain_no_req", {31'd0, data_req_o}, 32'd0);
    next_cycle();
    data_rvalid_i = 1'b1;
    #1;
    check_eq("drain_rdv", {31'd0, read_data_valid_o}, 32'd0);
    next_cycle();
    data_rvalid_i = 1'b0;
    check_eq("drain_idle", {31'd0, busy_o}, 32'd0);
    next_cycle();
    check_eq("drain_no_done", done_cnt - d0, 32'd0);

    // Kill in REQ without a grant returns straight to idle.
    start_load(32'h4100, 5'd4);
    wait_req("kill_req_req");
    kill_i = 1'b1;
    next_cycle();
    kill_i = 1'b0;
    check_eq("kill_req_idle", {31'd0, busy_o}, 32'd0);
    check_eq("kill_req_no_req", {31'd0, data_req_o}, 32'd0);

    // Reset while waiting for data; the late rvalid must be ignored.
    start_load(32'h5000, 5'd4);
    wait_req("rst_wait_req");
    data_gnt_i = 1'b1;
    next_cycle();
    data_gnt_i = 1'b0;
    rst_i = 1'b1;
    next_cycle();
    rst_i = 1'b0;
    check_eq("midrst_busy", {31'd0, busy_o}, 32'd0);
    check_eq("midrst_sel", {25'd0, byte_select_o}, 32'd0);
    check_eq("midrst_req", {31'd0, data_req_o}, 32'd0);
    data_rvalid_i = 1'b1;
    #1;
    check_eq("midrst_late_rdv", {31'd0, read_data_valid_o}, 32'd0);
    next_cycle();
    data_rvalid_i = 1'b0;
    check_eq("midrst_still_idle", {31'd0, busy_o}, 32'd0);

    exp_addr = '{32'h6000, 32'h0, 32'h0, 32'h0};
    exp_be   = '{4'hF, 4'h0, 4'h0, 4'h0};
    exp_sel  = '{7'd0, 7'd0, 7'd0, 7'd0};
    run_load("after_rst", 32'h6000, 5'd4, 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
